count_seq_checker: RTL

- Passive monitor on the output of a free-running up-counter; sits on the consumer side of the counter's `cnt` bus.
- Samples the count each qualified cycle and predicts the next value; flags skips, stalls and counter restarts.
- Keeps saturating error and wrap statistics for simulation scoreboards and on-chip debug.

---
 rtl/count_seq_if.sv | 27 ++
 rtl/count_seq_checker.sv | 104 ++++++++++
 2 files changed

// File: rtl/count_seq_if.sv
// Counter-observation bus: the counter side drives cnt_in/cnt_vld/clr_stats,
// the checker side returns tracking status and statistics.
interface count_seq_if #(
  parameter int WIDTH  = 7,
  parameter int STAT_W = 8
);
  logic [WIDTH-1:0]  cnt_in;
  logic              cnt_vld;
  logic              clr_stats;
  logic              locked;
  logic              err_pulse;
  logic              restart_pulse;
  logic              wrap_pulse;
  logic [WIDTH-1:0]  expected;
  logic [STAT_W-1:0] err_count;
  logic [STAT_W-1:0] wrap_count;

  modport master (
    output cnt_in, cnt_vld, clr_stats,
    input  locked, err_pulse, restart_pulse, wrap_pulse, expected, err_count, wrap_count
  );

  modport slave (
    input  cnt_in, cnt_vld, clr_stats,
    output locked, err_pulse, restart_pulse, wrap_pulse, expected, err_count, wrap_count
  );
endinterface

// File: rtl/count_seq_checker.sv
// Passive sequence checker for a free-running up-counter: predicts the next
// count, flags skips/stalls/restarts and keeps saturating error/wrap statistics.
module count_seq_checker #(
  parameter int WIDTH   = 7,
  parameter int MAX_VAL = 127,
  parameter int LOCK_N  = 4,
  parameter int STAT_W  = 8
) (
  input logic         clk,
  input logic         rst,
  count_seq_if.slave  mon
);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] TRACK  = 1'b1;

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
  localparam logic [3:0]       LOCK_V = 4'(LOCK_N);

  logic [0:0]        state_p1;
  logic [WIDTH-1:0]  expected_p1;
  logic              from_max_p1;
  logic [3:0]        run_p1;
  logic              locked_p1;
  logic              err_pulse_p1;
  logic              restart_pulse_p1;
  logic              wrap_pulse_p1;
  logic [STAT_W-1:0] err_count_p1;
  logic [STAT_W-1:0] wrap_count_p1;

  logic [3:0]        run_inc;
  logic              hit;

  function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
    return (x == MAX_V) ? '0 : x + WIDTH'(1);
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] x);
    return (x == '1) ? x : x + STAT_W'(1);
  endfunction

  assign run_inc = (run_p1 >= LOCK_V) ? LOCK_V : run_p1 + 4'd1;
  assign hit     = (mon.cnt_in == expected_p1);

  // Stage p0 -> p1: evaluate the qualified sample and register every output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1         <= SEARCH;
      expected_p1      <= '0;
      from_max_p1      <= 1'b0;
      run_p1           <= '0;
      locked_p1        <= 1'b0;
      err_pulse_p1     <= 1'b0;
      restart_pulse_p1 <= 1'b0;
      wrap_pulse_p1    <= 1'b0;
      err_count_p1     <= '0;
      wrap_count_p1    <= '0;
    end else begin
      err_pulse_p1     <= 1'b0;
      restart_pulse_p1 <= 1'b0;
      wrap_pulse_p1    <= 1'b0;
      if (mon.cnt_vld) begin
        expected_p1 <= nxt(mon.cnt_in);
        from_max_p1 <= (mon.cnt_in == MAX_V);
        if (state_p1 == SEARCH) begin
          run_p1   <= '0;
          state_p1 <= TRACK;
        end else if (hit) begin
          run_p1    <= run_inc;
          locked_p1 <= (run_inc == LOCK_V);
          // An expected 0 can also come from an out-of-range value truncating,
          // so only a prediction made from MAX_VAL counts as a wrap.
          if (mon.cnt_in == '0 && from_max_p1) begin
            wrap_pulse_p1 <= 1'b1;
            wrap_count_p1 <= sat_inc(wrap_count_p1);
          end
        end else if (mon.cnt_in == '0) begin
          restart_pulse_p1 <= 1'b1;
          locked_p1        <= 1'b0;
          run_p1           <= 4'd1;
        end else begin
          err_pulse_p1 <= 1'b1;
          err_count_p1 <= sat_inc(err_count_p1);
          locked_p1    <= 1'b0;
          run_p1       <= '0;
        end
      end
      // Clear takes priority over a same-cycle increment.
      if (mon.clr_stats) begin
        err_count_p1  <= '0;
        wrap_count_p1 <= '0;
      end
    end
  end

  assign mon.locked        = locked_p1;
  assign mon.err_pulse     = err_pulse_p1;
  assign mon.restart_pulse = restart_pulse_p1;
  assign mon.wrap_pulse    = wrap_pulse_p1;
  assign mon.expected      = expected_p1;
  assign mon.err_count     = err_count_p1;
  assign mon.wrap_count    = wrap_count_p1;

endmodule
